ds3502_responder: RTL and testbench
===================================

Name: ds3502_responder

Overview:
- I2C target (responder) model of the DS3502 digital potentiometer. It is the far end of the existing DS3502 I2C write master.
- Oversamples the SCL/SDA pins on clk, decodes START/STOP, matches the device address and runs register-address and data phases.
- Holds the WR (wiper) and CR registers and supports reads of the addressed register.
- Used in board-level loopback, in the bench for the master, and as a stand-in when no potentiometer is fitted.

Parameters:
- DEV_ADDR_HI, 5'b01010, upper 5 bits of the 7-bit device address.
- WR_RESET, 7'h40, wiper register reset value (mid-scale).
- SYNC_STAGES, 2, synchroniser depth on scl_i and sda_i (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- a1  in  1  address strap bit 1.
- a0  in  1  address strap bit 0.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release (open drain, external pull-up).
- wiper  out  7  WR register contents.
- cr  out  8  CR register contents.
- wr_strobe  out  1  one-cycle pulse on each committed register write.
- busy  out  1  high from an address-matched START until STOP or NACK release.

Behaviour:
- Reset (synchronous, active high, also mid-transfer): sda_oe=0, wiper=WR_RESET, cr=0x00, wr_strobe=0, busy=0, state=IDLE, pointer=0x00.
- Input path: SYNC_STAGES flops, then one history flop. Edge and event detection lags the pins by SYNC_STAGES+1 clks.
- START: synced SDA falls while SCL is high. STOP: synced SDA rises while SCL is high.
- START from any state (repeated start included): go to DEV_ADDR, bit_cnt=0, sda_oe=0 on the same cycle.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- START and STOP take priority over the bit-shift logic.
- Bit reception: SDA is shifted MSB first on each SCL rising edge; bit_cnt counts 0..8.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: after 8 bits, compare bits[7:1] with {DEV_ADDR_HI,a1,a0}.
    - Match: on the next SCL falling edge set sda_oe=1 and busy=1; go to DEV_ACK.
    - No match: go to IDLE with SDA untouched.
  - DEV_ACK: hold sda_oe until the next SCL falling edge, then release.
    - R/W=0: go to REG_ADDR.
    - R/W=1: load the shift register from the pointer and go to RD_DATA.
  - REG_ADDR: 8 bits, then load the pointer and ACK (same timing as DEV_ACK); go to WR_DATA.
  - WR_DATA: 8 bits. At the SCL falling edge that opens the ACK slot:
    - Commit the byte and pulse wr_strobe for 1 clk on the same cycle sda_oe rises.
    - Pointer 0x00: wiper = byte[6:0]; bit 7 is ignored.
    - Pointer 0x02: cr = byte.
    - Any other pointer: ACK, but nothing is stored and there is no strobe.
    - Pointer does not auto-increment; further bytes overwrite the same register.
  - RD_DATA:
    - Drive the MSB on the first SCL falling edge after DEV_ACK release, then one bit per falling edge.
    - A 1 bit means sda_oe=0; a 0 bit means sda_oe=1.
    - After 8 bits, release on the falling edge and go to RD_ACK.
    - Read values: pointer 0x00 returns {1'b0,wiper}; 0x02 returns cr; anything else returns 0x00.
  - RD_ACK: sample SDA on the SCL rising edge.
    - 0 (ACK): reload the same register and return to RD_DATA.
    - 1 (NACK): go to IDLE and drop busy; keep SDA released until STOP/START.
- sda_oe only changes on SCL-low edges, except on START, STOP or reset.
- A bit_cnt overflow cannot occur: the count is cleared on every state entry.

Decomposition:
- Shared package ds3502_pkg holds:
  - the DEV_ADDR_HI constant;
  - register addresses REG_WR=8'h00 and REG_CR=8'h02;
  - the state enum;
  - the WR_RESET default.
- One sub-module, i2c_line_sync: synchroniser plus edge/START/STOP detector. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- START, 0x50, 0x00, 0x2A, STOP with a1=a0=0 → three ACKs (sda_oe=1 in each ACK slot), wiper=0x2A, exactly one wr_strobe, busy=0 after STOP.
- START, 0x50, 0x00, 0x2A, Sr, 0x51, then the master clocks 8 bits and NACKs, STOP → bits read 0x2A, sda_oe=0 during the NACK slot, state IDLE.
- START, 0x50 with a1=1 → no ACK (SDA high at the 9th SCL rise), no strobe; repeat with 0x54 → ACK.
- Write 0x00 data 0xFF, then write 0x02 data 0x80 → wiper=0x7F, cr=0x80. Write 0x05 data 0x11 → ACKed, no strobe, registers unchanged.
- Write 0x00 followed by data bytes 0x10 and 0x20 in one transaction → two strobes, final wiper=0x20.
- Assert rst during the 4th data bit → the next clk has sda_oe=0, wiper=0x40, cr=0x00, busy=0; the following START, 0x50 transaction is ACKed normally.

Source files
------------

// File: rtl/ds3502_pkg.sv
// Shared constants and state encoding for the DS3502 I2C responder model.
package ds3502_pkg;

  localparam logic [4:0] DEV_ADDR_HI = 5'b01010;
  localparam logic [6:0] WR_RESET    = 7'h40;
  localparam logic [7:0] REG_WR      = 8'h00;
  localparam logic [7:0] REG_CR      = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } state_t;

endpackage

// File: rtl/ds3502_responder_i2c_line_sync.sv
// SCL/SDA synchroniser with one history stage; derives SCL edges and START/STOP.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_p1;
  logic                   sda_p1;

  // Pin levels carry no reset: a forced history value could fake a bus event.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    scl_p1   <= scl_s;
    sda_p1   <= sda_s;
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p1;
  assign scl_fall  = ~scl_s & scl_p1;
  assign start_det = scl_s & scl_p1 & sda_p1 & ~sda_s;
  assign stop_det  = scl_s & scl_p1 & ~sda_p1 & sda_s;

endmodule

// File: rtl/ds3502_responder.sv
// DS3502 digital potentiometer I2C target: WR/CR registers, pointer-addressed writes and reads.
module ds3502_responder #(
  parameter logic [4:0] DEV_ADDR_HI = ds3502_pkg::DEV_ADDR_HI,
  parameter logic [6:0] WR_RESET    = ds3502_pkg::WR_RESET,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a1,
  input  logic       a0,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [6:0] wiper,
  output logic [7:0] cr,
  output logic       wr_strobe,
  output logic       busy
);
  import ds3502_pkg::*;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;
  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] pointer;
  logic       rw;
  logic [7:0] rd_val;
  logic       rx_state;

  function automatic logic [7:0] reg_read(input logic [7:0] ptr, input logic [6:0] wr_v,
                                          input logic [7:0] cr_v);
    if (ptr == REG_WR) return {1'b0, wr_v};
    if (ptr == REG_CR) return cr_v;
    return 8'h00;
  endfunction

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign rd_val   = reg_read(pointer, wiper, cr);
  assign rx_state = (state == ST_DEV_ADDR) || (state == ST_REG_ADDR) || (state == ST_WR_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sda_oe    <= 1'b0;
      wiper     <= WR_RESET;
      cr        <= 8'h00;
      wr_strobe <= 1'b0;
      busy      <= 1'b0;
      pointer   <= 8'h00;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ST_DEV_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (scl_rise && rx_state) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ST_DEV_ADDR: if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == {DEV_ADDR_HI, a1, a0}) begin
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= shreg[0];
              state  <= ST_DEV_ACK;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          // The edge that ends the address ACK also presents the first read bit.
          ST_DEV_ACK: if (scl_fall) begin
            if (rw) begin
              sda_oe  <= ~rd_val[7];
              shreg   <= {rd_val[6:0], 1'b0};
              bit_cnt <= 4'd1;
              state   <= ST_RD_DATA;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= ST_REG_ADDR;
            end
          end
          ST_REG_ADDR: if (scl_fall && bit_cnt == 4'd8) begin
            pointer <= shreg;
            sda_oe  <= 1'b1;
            state   <= ST_REG_ACK;
          end
          ST_REG_ACK, ST_WR_ACK: if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            state   <= ST_WR_DATA;
          end
          ST_WR_DATA: if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe <= 1'b1;
            state  <= ST_WR_ACK;
            if (pointer == REG_WR) begin
              wiper     <= shreg[6:0];
              wr_strobe <= 1'b1;
            end else if (pointer == REG_CR) begin
              cr        <= shreg;
              wr_strobe <= 1'b1;
            end
          end
          ST_RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= ST_RD_ACK;
            end else begin
              sda_oe  <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (sda_s) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              shreg   <= rd_val;
              bit_cnt <= 4'd0;
              state   <= ST_RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds3502_responder.sv
// Randomised I2C master driving the DS3502 responder; scoreboard of 9-bit bus frames and register commits.
module tb_ds3502_responder;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1;
  logic       a0;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [6:0] wiper;
  logic [7:0] cr;
  logic       wr_strobe;
  logic       busy;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  ds3502_responder dut (
    .clk       (clk),
    .rst       (rst),
    .a1        (a1),
    .a0        (a0),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .wiper     (wiper),
    .cr        (cr),
    .wr_strobe (wr_strobe),
    .busy      (busy)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [8:0]  exp_frames[$];
  logic [14:0] exp_wr[$];
  logic [6:0]  m_wiper;
  logic [7:0]  m_cr;
  logic [7:0]  m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [7:0] addr_byte(input logic rd);
    return {5'b01010, a1, a0, rd};
  endfunction

  function automatic logic [7:0] model_read();
    if (m_ptr == 8'h00) return {1'b0, m_wiper};
    if (m_ptr == 8'h02) return m_cr;
    return 8'h00;
  endfunction

  task automatic bus_start();
    tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic bus_bit(input logic b);
    tick(Q); sda_m = b; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack_level);
    exp_frames.push_back({b, exp_ack_level});
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_bit(1'b1);
  endtask

  task automatic read_byte(input logic nack);
    exp_frames.push_back({model_read(), nack});
    for (int i = 0; i < 8; i++) bus_bit(1'b1);
    bus_bit(nack);
  endtask

  task automatic send_data(input logic [7:0] d);
    if (m_ptr == 8'h00) begin
      m_wiper = d[6:0];
      exp_wr.push_back({m_wiper, m_cr});
    end else if (m_ptr == 8'h02) begin
      m_cr = d;
      exp_wr.push_back({m_wiper, m_cr});
    end
    send_byte(d, 1'b0);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d[$]);
    bus_start();
    send_byte(addr_byte(1'b0), 1'b0);
    send_byte(ptr, 1'b0);
    m_ptr = ptr;
    foreach (d[i]) send_data(d[i]);
    bus_stop();
    tick(4);
    check("busy_after_stop", busy, 1'b0);
  endtask

  task automatic read_txn(input logic [7:0] ptr, input int n);
    bus_start();
    send_byte(addr_byte(1'b0), 1'b0);
    send_byte(ptr, 1'b0);
    m_ptr = ptr;
    bus_start();
    send_byte(addr_byte(1'b1), 1'b0);
    check("busy_in_read", busy, 1'b1);
    for (int k = 0; k < n; k++) read_byte(k == n - 1);
    check("busy_after_nack", busy, 1'b0);
    bus_stop();
  endtask

  // Bus monitor: frames the line into 9-bit groups between START/STOP conditions.
  initial begin : line_mon
    logic       ps;
    logic       pd;
    int         cnt;
    logic [8:0] fr;
    ps = 1'b1; pd = 1'b1; cnt = 0; fr = '0;
    forever begin
      @(scl or sda_line);
      if (scl && ps && (sda_line != pd)) cnt = 0;
      else if (scl && !ps) begin
        fr = {fr[7:0], sda_line};
        cnt++;
        if (cnt == 9) begin
          cnt = 0;
          if (exp_frames.size() == 0) begin
            n_chk++;
            $display("FAIL frame_extra: got 0x%0h expected none", fr);
          end else check("frame", fr, exp_frames.pop_front());
        end
      end
      ps = scl;
      pd = sda_line;
    end
  end

  // Commit monitor: each wr_strobe must match the next expected register image.
  initial begin : wr_mon
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (wr_strobe === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          $display("FAIL strobe_extra: got wiper 0x%0h cr 0x%0h expected no strobe", wiper, cr);
        end else begin
          e = exp_wr.pop_front();
          check("strobe_wiper", wiper, e[14:8]);
          check("strobe_cr", cr, e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] ptr;
    int         n;
    rst = 1'b1; a1 = 1'b0; a0 = 1'b0; scl = 1'b1; sda_m = 1'b1;
    m_wiper = 7'h40; m_cr = 8'h00; m_ptr = 8'h00;
    tick(6);
    rst = 1'b0;
    #1;
    check("rst_wiper", wiper, 7'h40);
    check("rst_cr", cr, 8'h00);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);

    q = '{8'h2A}; write_txn(8'h00, q);
    check("wiper_2a", wiper, 7'h2A);

    bus_start();
    send_byte(addr_byte(1'b0), 1'b0);
    send_byte(8'h00, 1'b0);
    m_ptr = 8'h00;
    send_data(8'h2A);
    bus_start();
    send_byte(addr_byte(1'b1), 1'b0);
    read_byte(1'b1);
    bus_stop();
    tick(4);
    check("rd_idle_busy", busy, 1'b0);

    a1 = 1'b1;
    bus_start();
    send_byte(8'h50, 1'b1);
    check("nomatch_busy", busy, 1'b0);
    check("nomatch_sda_oe", sda_oe, 1'b0);
    bus_stop();
    bus_start();
    send_byte(8'h54, 1'b0);
    check("match_a1_busy", busy, 1'b1);
    bus_stop();
    a1 = 1'b0;

    q = '{8'hFF}; write_txn(8'h00, q);
    q = '{8'h80}; write_txn(8'h02, q);
    q = '{8'h11}; write_txn(8'h05, q);
    check("reg_wiper_7f", wiper, 7'h7F);
    check("reg_cr_80", cr, 8'h80);
    q = '{8'h10, 8'h20}; write_txn(8'h00, q);
    check("multi_wiper", wiper, 7'h20);

    for (int it = 0; it < 14; it++) begin
      a1 = 1'($urandom_range(0, 1));
      a0 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ptr = 8'h00;
        1: ptr = 8'h02;
        default: ptr = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        q = {};
        for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
        write_txn(ptr, q);
      end else read_txn(ptr, n);
      check("rnd_wiper", wiper, m_wiper);
      check("rnd_cr", cr, m_cr);
    end
    a1 = 1'b0; a0 = 1'b0;

    q = '{8'hC3}; write_txn(8'h02, q);
    q = '{8'h15}; write_txn(8'h00, q);
    bus_start();
    send_byte(addr_byte(1'b0), 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) bus_bit(1'b1);
    tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(2);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_wiper = 7'h40; m_cr = 8'h00; m_ptr = 8'h00;
    check("midrst_sda_oe", sda_oe, 1'b0);
    check("midrst_wiper", wiper, 7'h40);
    check("midrst_cr", cr, 8'h00);
    check("midrst_busy", busy, 1'b0);
    tick(Q); scl = 1'b0;
    bus_stop();
    q = '{8'h33}; write_txn(8'h00, q);
    check("post_rst_wiper", wiper, 7'h33);

    tick(50);
    check("frames_drained", exp_frames.size(), 0);
    check("strobes_drained", exp_wr.size(), 0);
    check("final_wiper", wiper, m_wiper);
    check("final_cr", cr, m_cr);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
